// File: rtl/tri_setup_queue.sv
// Triangle setup stage: signed doubled area, culling, iterative 2^FRAC/|area|
// divide, and a show-ahead FIFO feeding the rasterizer.
module tri_setup_queue #(
    parameter int unsigned XW        = 9,
    parameter int unsigned YW        = 8,
    parameter int unsigned ZW        = 16,
    parameter int unsigned CW        = 8,
    parameter int unsigned FRAC      = 24,
    parameter int unsigned INV_W     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CULL_MODE = 0
) (
    input  logic             axi_aclk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XW-1:0]    in_v1x,
    input  logic [XW-1:0]    in_v2x,
    input  logic [XW-1:0]    in_v3x,
    input  logic [YW-1:0]    in_v1y,
    input  logic [YW-1:0]    in_v2y,
    input  logic [YW-1:0]    in_v3y,
    input  logic [ZW-1:0]    in_z1,
    input  logic [ZW-1:0]    in_z2,
    input  logic [ZW-1:0]    in_z3,
    input  logic [CW-1:0]    in_color,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XW-1:0]    out_v1x,
    output logic [XW-1:0]    out_v2x,
    output logic [XW-1:0]    out_v3x,
    output logic [YW-1:0]    out_v1y,
    output logic [YW-1:0]    out_v2y,
    output logic [YW-1:0]    out_v3y,
    output logic [ZW-1:0]    out_z1,
    output logic [ZW-1:0]    out_z2,
    output logic [ZW-1:0]    out_z3,
    output logic [CW-1:0]    out_color,
    output logic [INV_W-1:0] out_inv_area,
    output logic             out_ccw,
    output logic [15:0]      culled_cnt,
    output logic             busy
);
    localparam int unsigned AW   = XW + YW + 2;
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned BW   = $clog2(INV_W);

    typedef struct packed {
        logic [XW-1:0] v1x, v2x, v3x;
        logic [YW-1:0] v1y, v2y, v3y;
        logic [ZW-1:0] z1, z2, z3;
        logic [CW-1:0] color;
    } tri_t;

    typedef struct packed {
        tri_t             t;
        logic [INV_W-1:0] inv;
        logic             ccw;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_AREA, S_DIV, S_PUSH} state_t;

    state_t            r_state, w_next_state;
    tri_t              r_tri;
    logic [AW-1:0]     r_div, r_rem;
    logic [INV_W-1:0]  r_quot;
    logic [BW-1:0]     r_bit;
    logic              r_ccw;
    logic [15:0]       r_culled;
    entry_t            r_mem [DEPTH];
    logic [PW-1:0]     r_wr, r_rd;
    logic [CNTW-1:0]   r_count;

    logic signed [AW-1:0] w_x1, w_x2, w_x3, w_y1, w_y2, w_y3, w_area;
    logic [AW-1:0]     w_abs, w_rem_nx;
    logic [AW:0]       w_rem_sh;
    logic              w_cull, w_qbit, w_full, w_push, w_pop;
    entry_t            w_entry, w_head;

    // Signed doubled area; intermediate terms may wrap, the final sum fits in AW bits
    always_comb begin
        w_x1   = signed'(AW'(r_tri.v1x));
        w_x2   = signed'(AW'(r_tri.v2x));
        w_x3   = signed'(AW'(r_tri.v3x));
        w_y1   = signed'(AW'(r_tri.v1y));
        w_y2   = signed'(AW'(r_tri.v2y));
        w_y3   = signed'(AW'(r_tri.v3y));
        w_area = w_x1 * (w_y2 - w_y3) + w_x2 * (w_y3 - w_y1) + w_x3 * (w_y1 - w_y2);
        w_abs  = w_area[AW-1] ? unsigned'(-w_area) : unsigned'(w_area);
        w_cull = (w_area == '0)
              || ((CULL_MODE == 32'd1) && w_area[AW-1])
              || ((CULL_MODE == 32'd2) && !w_area[AW-1]);
    end

    // One restoring step; dividend 2^FRAC has a single set bit at index FRAC
    always_comb begin
        w_rem_sh = {r_rem, (r_bit == BW'(FRAC))};
        w_qbit   = (w_rem_sh >= {1'b0, r_div});
        w_rem_nx = w_qbit ? AW'(w_rem_sh - {1'b0, r_div}) : AW'(w_rem_sh);
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_next_state = S_AREA;
                S_AREA:  w_next_state = w_cull ? S_IDLE : S_DIV;
                S_DIV:   if (r_bit == '0) w_next_state = S_PUSH;
                S_PUSH:  if (w_push) w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // A full FIFO still takes the push when its head leaves in the same cycle
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        w_full    = 1'b0;
        w_pop     = 1'b0;
        w_push    = 1'b0;
        out_valid = (r_count != '0);
        w_full    = (r_count == CNTW'(DEPTH));
        w_pop     = out_valid && out_ready;
        w_push    = (r_state == S_PUSH) && (!w_full || w_pop);
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE) || out_valid;
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_tri    <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_bit    <= '0;
            r_ccw    <= 1'b0;
            r_culled <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_tri.v1x   <= in_v1x;
                    r_tri.v2x   <= in_v2x;
                    r_tri.v3x   <= in_v3x;
                    r_tri.v1y   <= in_v1y;
                    r_tri.v2y   <= in_v2y;
                    r_tri.v3y   <= in_v3y;
                    r_tri.z1    <= in_z1;
                    r_tri.z2    <= in_z2;
                    r_tri.z3    <= in_z3;
                    r_tri.color <= in_color;
                end
                S_AREA: if (w_cull) begin
                    if (r_culled != 16'hFFFF) r_culled <= r_culled + 16'd1;
                end else begin
                    r_div <= w_abs;
                    r_ccw <= !w_area[AW-1];
                    r_rem <= '0;
                    r_bit <= BW'(INV_W - 1);
                end
                S_DIV: begin
                    r_rem  <= w_rem_nx;
                    r_quot <= {r_quot[INV_W-2:0], w_qbit};
                    r_bit  <= r_bit - BW'(1);
                end
                default: ;
            endcase
        end
    end

    assign w_entry = {r_tri, r_quot, r_ccw};

    // Entries are cleared on reset so the head fields read zero
    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[PW'(i)] <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_entry;
                r_wr        <= r_wr + PW'(1);
            end
            if (w_pop) r_rd <= r_rd + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNTW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNTW'(1);
        end
    end

    assign w_head       = r_mem[r_rd];
    assign out_v1x      = w_head.t.v1x;
    assign out_v2x      = w_head.t.v2x;
    assign out_v3x      = w_head.t.v3x;
    assign out_v1y      = w_head.t.v1y;
    assign out_v2y      = w_head.t.v2y;
    assign out_v3y      = w_head.t.v3y;
    assign out_z1       = w_head.t.z1;
    assign out_z2       = w_head.t.z2;
    assign out_z3       = w_head.t.z3;
    assign out_color    = w_head.t.color;
    assign out_inv_area = w_head.inv;
    assign out_ccw      = w_head.ccw;
    assign culled_cnt   = r_culled;
endmodule

// File: tb/tb_tri_setup_queue.sv
// Bench for tri_setup_queue: directed cases plus random triangles checked
// against an arithmetic model of area, culling and floor(2^FRAC/|area|).
module tb_tri_setup_queue;
    localparam int unsigned XW = 9, YW = 8, ZW = 16, CW = 8;
    localparam int unsigned FRAC = 24, INV_W = 32, DEPTH = 4, CULL = 1;

    typedef struct packed {
        logic [8:0]  x1, x2, x3;
        logic [7:0]  y1, y2, y3;
        logic [15:0] z1, z2, z3;
        logic [7:0]  c;
    } tb_tri_t;

    logic clk = 1'b0;
    logic reset, flush, in_valid, in_ready, out_valid, out_ready, out_ccw, busy;
    logic [XW-1:0] in_v1x, in_v2x, in_v3x, out_v1x, out_v2x, out_v3x;
    logic [YW-1:0] in_v1y, in_v2y, in_v3y, out_v1y, out_v2y, out_v3y;
    logic [ZW-1:0] in_z1, in_z2, in_z3, out_z1, out_z2, out_z3;
    logic [CW-1:0] in_color, out_color;
    logic [INV_W-1:0] out_inv_area;
    logic [15:0] culled_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_culled = 0;

    always #5 clk = ~clk;

    tri_setup_queue #(.XW(XW), .YW(YW), .ZW(ZW), .CW(CW), .FRAC(FRAC),
                      .INV_W(INV_W), .DEPTH(DEPTH), .CULL_MODE(CULL)) dut (
        .axi_aclk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_v1x(in_v1x), .in_v2x(in_v2x), .in_v3x(in_v3x),
        .in_v1y(in_v1y), .in_v2y(in_v2y), .in_v3y(in_v3y),
        .in_z1(in_z1), .in_z2(in_z2), .in_z3(in_z3), .in_color(in_color),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_v1x(out_v1x), .out_v2x(out_v2x), .out_v3x(out_v3x),
        .out_v1y(out_v1y), .out_v2y(out_v2y), .out_v3y(out_v3y),
        .out_z1(out_z1), .out_z2(out_z2), .out_z3(out_z3), .out_color(out_color),
        .out_inv_area(out_inv_area), .out_ccw(out_ccw),
        .culled_cnt(culled_cnt), .busy(busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_area(input tb_tri_t t);
        return int'(t.x1) * (int'(t.y2) - int'(t.y3))
             + int'(t.x2) * (int'(t.y3) - int'(t.y1))
             + int'(t.x3) * (int'(t.y1) - int'(t.y2));
    endfunction

    function automatic logic [31:0] model_inv(input int a);
        longint m, q;
        m = (a < 0) ? -longint'(a) : longint'(a);
        q = (longint'(1) <<< FRAC) / m;
        return q[31:0];
    endfunction

    function automatic bit model_cull(input int a);
        return (a == 0) || ((CULL == 1) && (a < 0)) || ((CULL == 2) && (a > 0));
    endfunction

    function automatic tb_tri_t mk(input int ax, ay, bx, by, cx, cy, z, c);
        tb_tri_t t;
        t.x1 = 9'(ax); t.y1 = 8'(ay); t.x2 = 9'(bx); t.y2 = 8'(by);
        t.x3 = 9'(cx); t.y3 = 8'(cy);
        t.z1 = 16'(z); t.z2 = 16'(z); t.z3 = 16'(z); t.c = 8'(c);
        return t;
    endfunction

    function automatic tb_tri_t rand_tri();
        tb_tri_t t;
        t.x1 = 9'($urandom_range(0, 511)); t.x2 = 9'($urandom_range(0, 511));
        t.x3 = 9'($urandom_range(0, 511));
        t.y1 = 8'($urandom_range(0, 255)); t.y2 = 8'($urandom_range(0, 255));
        t.y3 = 8'($urandom_range(0, 255));
        t.z1 = 16'($urandom); t.z2 = 16'($urandom); t.z3 = 16'($urandom);
        t.c  = 8'($urandom);
        return t;
    endfunction

    // Random triangle with strictly positive area (swapping two vertices flips the sign)
    function automatic tb_tri_t rand_pos();
        tb_tri_t t;
        logic [8:0] sx;
        logic [7:0] sy;
        t = rand_tri();
        for (int k = 0; k < 100 && model_area(t) == 0; k++) t = rand_tri();
        if (model_area(t) == 0) t = mk(0, 0, 1, 0, 0, 1, 7, 7);
        if (model_area(t) < 0) begin
            sx = t.x2; t.x2 = t.x3; t.x3 = sx;
            sy = t.y2; t.y2 = t.y3; t.y3 = sy;
        end
        return t;
    endfunction

    task automatic drive(input tb_tri_t t);
        in_v1x = t.x1; in_v2x = t.x2; in_v3x = t.x3;
        in_v1y = t.y1; in_v2y = t.y2; in_v3y = t.y3;
        in_z1 = t.z1; in_z2 = t.z2; in_z3 = t.z3; in_color = t.c;
    endtask

    task automatic submit(input tb_tri_t t);
        int k = 0;
        while (!in_ready && k < 400) begin @(negedge clk); k++; end
        check("in_ready_wait", 128'(in_ready), 128'(1));
        drive(t);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_head(input tb_tri_t t, input string tag);
        int a;
        a = model_area(t);
        check({tag, "_valid"}, 128'(out_valid), 128'(1));
        check({tag, "_data"}, 128'({out_v1x, out_v2x, out_v3x, out_v1y, out_v2y, out_v3y,
                                    out_z1, out_z2, out_z3, out_color}), 128'(t));
        check({tag, "_inv"}, 128'(out_inv_area), 128'(model_inv(a)));
        check({tag, "_ccw"}, 128'(out_ccw), 128'(a > 0));
    endtask

    // Accept-edge counts as edge 1; out_valid must rise on edge INV_W+3
    task automatic send_pass(input tb_tri_t t, input string tag);
        int lat = 0;
        submit(t);
        while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
        check({tag, "_latency"}, 128'(lat + 1), 128'(INV_W + 3));
        check_head(t, tag);
        @(negedge clk);
        check({tag, "_drained"}, 128'(out_valid), 128'(0));
        check({tag, "_culled"}, 128'(culled_cnt), 128'(exp_culled));
    endtask

    task automatic send_cull(input tb_tri_t t, input string tag);
        submit(t);
        exp_culled++;
        @(negedge clk);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        check({tag, "_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_culled"}, 128'(culled_cnt), 128'(exp_culled));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_culled"}, 128'(culled_cnt), 128'(0));
        check({tag, "_data"}, 128'({out_v1x, out_v2x, out_v3x, out_v1y, out_v2y, out_v3y,
                                    out_z1, out_z2, out_z3, out_color, out_inv_area, out_ccw}), 128'(0));
    endtask

    initial begin
        tb_tri_t t;
        tb_tri_t q[$];
        int a;
        int k;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        send_pass(mk(40, 20, 140, 120, 40, 120, 50, 8'hE0), "t1");
        check("t1_inv_const", 128'(model_inv(10000)), 128'(32'h0000068D));
        send_cull(mk(140, 20, 90, 70, 190, 70, 50, 8'h1C), "t2");
        send_cull(mk(0, 0, 10, 10, 20, 20, 1, 1), "collinear");
        send_pass(mk(0, 0, 1, 0, 0, 1, 3, 3), "unit_area");
        send_pass(mk(0, 0, 511, 0, 0, 255, 9, 9), "max_area");

        for (int i = 0; i < 16; i++) begin
            t = rand_tri();
            a = model_area(t);
            if (model_cull(a)) send_cull(t, "rand_cull");
            else               send_pass(t, "rand_pass");
        end

        // Backpressure: DEPTH entries queued, one more stalled in PUSH
        out_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            t = rand_pos();
            q.push_back(t);
            submit(t);
        end
        repeat (INV_W + 8) @(negedge clk);
        check("bp_in_ready", 128'(in_ready), 128'(0));
        check("bp_busy", 128'(busy), 128'(1));
        check_head(q[0], "bp_head");
        repeat (5) @(negedge clk);
        check_head(q[0], "bp_stable");
        out_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            k = 0;
            while (!out_valid && k < 200) begin @(negedge clk); k++; end
            check_head(q[i], "bp_drain");
            @(negedge clk);
        end
        check("bp_empty", 128'(out_valid), 128'(0));
        check("bp_idle", 128'(busy), 128'(0));

        // Flush mid-divide with two entries queued; a same-cycle in_valid is ignored
        out_ready = 1'b0;
        submit(rand_pos());
        submit(rand_pos());
        submit(rand_pos());
        repeat (10) @(negedge clk);
        check("fl_pre_valid", 128'(out_valid), 128'(1));
        check("fl_pre_busy", 128'(busy), 128'(1));
        flush = 1'b1;
        drive(rand_pos());
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 128'(out_valid), 128'(0));
        check("fl_in_ready", 128'(in_ready), 128'(1));
        check("fl_busy", 128'(busy), 128'(0));
        check("fl_culled_kept", 128'(culled_cnt), 128'(exp_culled));
        repeat (3) @(negedge clk);
        check("fl_no_accept", 128'(busy), 128'(0));
        out_ready = 1'b1;
        send_pass(rand_pos(), "post_flush");

        // Asynchronous reset mid-divide with an entry queued
        out_ready = 1'b0;
        submit(rand_pos());
        submit(rand_pos());
        repeat (10) @(negedge clk);
        check("rs_pre_valid", 128'(out_valid), 128'(1));
        #2 reset = 1'b1;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b0;
        exp_culled = 0;
        out_ready = 1'b1;
        @(negedge clk);
        send_pass(rand_pos(), "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
